sram_controller: RTL

//  Memory-side responder for the MEM stage's data-memory requests (mem_read_en/mem_write_en, alu_re_addr, val_rm).

---
 rtl/sram_controller_pkg.sv | 18 +
 rtl/sram_controller.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the data-memory SRAM controller: FSM states and
// default geometry of the external 16-bit asynchronous SRAM.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_e;

    localparam int unsigned HALF_CYCLES_DEF = 2;
    localparam int unsigned BASE_ADDR_DEF   = 1024;
    localparam int unsigned SRAM_AW_DEF     = 18;
    localparam int unsigned SRAM_DW         = 16;
    localparam int unsigned WORD_W          = 32;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage data-memory responder: each 32-bit word access becomes two
// 16-bit accesses (low then high half) on an external asynchronous SRAM.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned HALF_CYCLES = HALF_CYCLES_DEF,
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
    parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [WORD_W-1:0]    address,
    input  logic [WORD_W-1:0]    write_data,
    output logic [WORD_W-1:0]    read_data,
    output logic                 ready,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [SRAM_DW-1:0]   sram_dq_out,
    input  logic [SRAM_DW-1:0]   sram_dq_in,
    output logic                 sram_dq_oe,
    output logic                 sram_we_n
);

    localparam int unsigned WW = SRAM_AW - 1;
    localparam int unsigned CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(HALF_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [WW-1:0]       word_q, word_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [SRAM_DW-1:0]  dq_out_q, dq_out_d;
    logic                oe_q, oe_d;
    logic                we_n_q, we_n_d;
    logic [WW-1:0]       req_word;
    logic                last_cnt;

    assign req_word = WW'((address - BASE_ADDR) >> 2);
    assign last_cnt = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_wr_q  <= 1'b0;
            word_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
            oe_q     <= 1'b0;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            word_q   <= word_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            oe_q     <= oe_d;
            we_n_q   <= we_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (wr_en || rd_en) begin
                    op_wr_d = wr_en;
                    word_d  = req_word;
                    wdata_d = write_data;
                    cnt_d   = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (last_cnt) begin
                    if (!op_wr_q) rdata_d[15:0] = sram_dq_in;
                    cnt_d   = '0;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (last_cnt) begin
                    if (!op_wr_q) rdata_d[31:16] = sram_dq_in;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM pins are registered, so they are derived from the next state and
    // count: the pins then line up with the state the FSM is in.
    always_comb begin
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        oe_d     = 1'b0;
        we_n_d   = 1'b1;
        ready    = (state_q == DONE) || ((state_q == IDLE) && !wr_en && !rd_en);
        if (state_d == LOW || state_d == HIGH) begin
            addr_d = {word_d, (state_d == HIGH)};
            if (op_wr_d) begin
                oe_d     = 1'b1;
                dq_out_d = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
                we_n_d   = (HALF_CYCLES > 1) && (cnt_d == LAST_CNT);
            end
        end
    end

    assign read_data   = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

endmodule
